dense_head: RTL and testbench

Fully-connected output stage that runs after the convolution engine finishes. It reads the flattened layer-2 feature memory (`csel` = 3'b101) through the shared layer-memory read port. For each of `N_OUT` neurons it multiply-accumulates those features against signed weights from an external weight memory, adds a per-neuron bias, and rounds and clips the sum. It emits one 20-bit score per neuron on a valid strobe. A top-level controller pulses `start` after the convolution engine drops `busy`.

---
 rtl/dense_pkg.sv | 35 +++
 rtl/dense_mac.sv | 63 ++++++
 rtl/dense_head.sv | 155 +++++++++++++++
 tb/tb_dense_head.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dense_pkg.sv
// Shared types, widths and the score clip for the dense output stage.
// DENSE_RELU_EN selects ReLU clipping; otherwise scores saturate to signed 20 bits.
package dense_pkg;

   localparam int DATA_W = 20;
   localparam int FRAC_W = 16;
   localparam int ACC_W  = 48;

   localparam logic [2:0] CSEL_L2   = 3'b101;
   localparam logic [2:0] CSEL_NONE = 3'b000;

   typedef enum logic [2:0] {IDLE, FETCH, BIAS, DRAIN, OUT, DONE} state_e;

   // Maps the rounded 16.16 sum onto the 20-bit output range.
   function automatic logic [DATA_W-1:0] clipScore(input logic signed [31:0] r);
      logic [DATA_W-1:0] res;
`ifdef DENSE_RELU_EN
      if (r < 0)
         res = '0;
      else if (r > 32'sh7FFFF)
         res = 20'h7FFFF;
      else
         res = r[DATA_W-1:0];
`else
      if (r < -32'sh80000)
         res = 20'h80000;
      else if (r > 32'sh7FFFF)
         res = 20'h7FFFF;
      else
         res = r[DATA_W-1:0];
`endif
      return res;
   endfunction

endpackage

// File: rtl/dense_mac.sv
// Two-stage multiply-accumulate for one neuron: operand register, then 48-bit
// accumulate of product or aligned bias, followed by round-half-up and clip.
module dense_mac
   import dense_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear_i,
   input  logic              featVld_i,
   input  logic              biasVld_i,
   input  logic [DATA_W-1:0] feat_i,
   input  logic [DATA_W-1:0] wt_i,
   output logic [DATA_W-1:0] score_o
);

   logic [DATA_W-1:0]       feat_q;
   logic [DATA_W-1:0]       wt_q;
   logic                    prodVld_q;
   logic                    biasVld_q;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] acc_d;
   logic signed [ACC_W-1:0] featX;
   logic signed [ACC_W-1:0] wtX;
   logic signed [ACC_W-1:0] prod;
   logic signed [ACC_W-1:0] biasX;
   logic signed [31:0]      rounded;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         feat_q    <= '0;
         wt_q      <= '0;
         prodVld_q <= 1'b0;
         biasVld_q <= 1'b0;
         acc_q     <= '0;
      end else begin
         feat_q    <= feat_i;
         wt_q      <= wt_i;
         prodVld_q <= featVld_i;
         biasVld_q <= biasVld_i;
         acc_q     <= acc_d;
      end
   end

   // Features are unsigned so they are zero-extended; the bias shares the
   // weight register and is shifted up to the 8.32 product scale.
   always_comb begin
      featX   = {{(ACC_W-DATA_W){1'b0}}, feat_q};
      wtX     = {{(ACC_W-DATA_W){wt_q[DATA_W-1]}}, wt_q};
      prod    = featX * wtX;
      biasX   = {{(ACC_W-DATA_W-FRAC_W){wt_q[DATA_W-1]}}, wt_q, {FRAC_W{1'b0}}};
      acc_d   = acc_q;
      if (clear_i)
         acc_d = '0;
      else if (prodVld_q)
         acc_d = acc_q + prod;
      else if (biasVld_q)
         acc_d = acc_q + biasX;
      rounded = acc_q[ACC_W-1:FRAC_W] + 32'(acc_q[FRAC_W-1]);
   end

   assign score_o = clipScore(rounded);

endmodule

// File: rtl/dense_head.sv
// Fully-connected output stage: streams layer-2 features and weights through
// dense_mac per neuron and emits one clipped score each (clip mode: DENSE_RELU_EN).
module dense_head
   import dense_pkg::*;
#(
   parameter  int N_IN  = 2048,
   parameter  int N_OUT = 4,
   parameter  int WA_W  = $clog2(N_OUT*N_IN+N_OUT),
   localparam int IW    = (N_OUT > 1) ? $clog2(N_OUT) : 1
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              crd,
   output logic [11:0]       caddr_rd,
   output logic [2:0]        csel,
   input  logic [DATA_W-1:0] cdata_rd,
   output logic              wrd,
   output logic [WA_W-1:0]   waddr,
   input  logic [DATA_W-1:0] wdata,
   output logic              out_valid,
   output logic [IW-1:0]     out_idx,
   output logic [DATA_W-1:0] out_data,
   output logic              done
);

   localparam int KW = (N_IN > 1) ? $clog2(N_IN) : 1;

   state_e            state_q;
   logic [KW-1:0]     k_q;
   logic [IW-1:0]     n_q;
   logic              drain_q;
   logic              busy_q;
   logic              crd_q;
   logic              wrd_q;
   logic [11:0]       caddr_q;
   logic [WA_W-1:0]   waddr_q;
   logic [2:0]        csel_q;
   logic              outValid_q;
   logic [IW-1:0]     outIdx_q;
   logic [DATA_W-1:0] outData_q;
   logic              done_q;

   logic              accept;
   logic              lastK;
   logic              lastN;
   logic              clearAcc;
   logic [DATA_W-1:0] score;

   // busy is still high while the done pulse is out, which blocks an early restart.
   assign accept   = (state_q == IDLE) && start && !busy_q;
   assign lastK    = (k_q == KW'(N_IN-1));
   assign lastN    = (n_q == IW'(N_OUT-1));
   assign clearAcc = accept || ((state_q == OUT) && !lastN);

   // Memory strobes and addresses lag the state by one cycle so every output is a flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         k_q        <= '0;
         n_q        <= '0;
         drain_q    <= 1'b0;
         busy_q     <= 1'b0;
         crd_q      <= 1'b0;
         wrd_q      <= 1'b0;
         caddr_q    <= '0;
         waddr_q    <= '0;
         csel_q     <= CSEL_NONE;
         outValid_q <= 1'b0;
         outIdx_q   <= '0;
         outData_q  <= '0;
         done_q     <= 1'b0;
      end else begin
         crd_q      <= 1'b0;
         wrd_q      <= 1'b0;
         csel_q     <= CSEL_NONE;
         outValid_q <= 1'b0;
         done_q     <= 1'b0;
         if (done_q)
            busy_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q <= FETCH;
                  busy_q  <= 1'b1;
                  k_q     <= '0;
                  n_q     <= '0;
               end
            end
            FETCH: begin
               crd_q   <= 1'b1;
               wrd_q   <= 1'b1;
               csel_q  <= CSEL_L2;
               caddr_q <= 12'(k_q);
               waddr_q <= WA_W'(n_q) * WA_W'(N_IN) + WA_W'(k_q);
               k_q     <= k_q + KW'(1);
               if (lastK)
                  state_q <= BIAS;
            end
            BIAS: begin
               wrd_q   <= 1'b1;
               waddr_q <= WA_W'(N_OUT*N_IN) + WA_W'(n_q);
               drain_q <= 1'b0;
               state_q <= DRAIN;
            end
            DRAIN: begin
               drain_q <= 1'b1;
               if (drain_q)
                  state_q <= OUT;
            end
            OUT: begin
               outValid_q <= 1'b1;
               outIdx_q   <= n_q;
               outData_q  <= score;
               if (lastN) begin
                  state_q <= DONE;
               end else begin
                  n_q     <= n_q + IW'(1);
                  k_q     <= '0;
                  state_q <= FETCH;
               end
            end
            DONE: begin
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   dense_mac uMac (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (clearAcc),
      .featVld_i (crd_q),
      .biasVld_i (wrd_q && !crd_q),
      .feat_i    (cdata_rd),
      .wt_i      (wdata),
      .score_o   (score)
   );

   assign busy      = busy_q;
   assign crd       = crd_q;
   assign caddr_rd  = caddr_q;
   assign csel      = csel_q;
   assign wrd       = wrd_q;
   assign waddr     = waddr_q;
   assign out_valid = outValid_q;
   assign out_idx   = outIdx_q;
   assign out_data  = outData_q;
   assign done      = done_q;

endmodule

// File: tb/tb_dense_head.sv
// Bench for dense_head (N_IN=16, N_OUT=2): arithmetic reference model checked every
// cycle, plus hand-computed literals per scenario. Clip mode follows DENSE_RELU_EN.
module tb_dense_head;

   localparam int N_IN  = 16;
   localparam int N_OUT = 2;
   localparam int WA_W  = $clog2(N_OUT*N_IN+N_OUT);
   localparam int IW    = 1;
   localparam int PER   = N_IN + 4;
   localparam int TOTAL = N_OUT * PER;
`ifdef DENSE_RELU_EN
   localparam logic [19:0] S2_EXP = 20'h00000;
`else
   localparam logic [19:0] S2_EXP = 20'hF0000;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic            busy;
   logic            crd;
   logic [11:0]     caddr_rd;
   logic [2:0]      csel;
   logic [19:0]     cdata_rd;
   logic            wrd;
   logic [WA_W-1:0] waddr;
   logic [19:0]     wdata;
   logic            out_valid;
   logic [IW-1:0]   out_idx;
   logic [19:0]     out_data;
   logic            done;

   logic [19:0] featMem [N_IN];
   logic [19:0] wMem    [N_OUT*N_IN+N_OUT];
   logic [19:0] expData [N_OUT];
   logic [19:0] gotData [N_OUT];

   int checks = 0;
   int errors = 0;
   int cycleCnt = 0;
   int acceptCycle = 0;
   int validCount = 0;
   int doneCount = 0;
   int doneRel = -1;
   bit active = 1'b0;
   logic [IW-1:0] heldIdx = '0;
   logic [19:0]   heldData = '0;

   int c, nn, j;
   bit eBusy, eCrd, eWrd, eValid, eDone;

   dense_head #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .busy      (busy),
      .crd       (crd),
      .caddr_rd  (caddr_rd),
      .csel      (csel),
      .cdata_rd  (cdata_rd),
      .wrd       (wrd),
      .waddr     (waddr),
      .wdata     (wdata),
      .out_valid (out_valid),
      .out_idx   (out_idx),
      .out_data  (out_data),
      .done      (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Memories answer combinationally to the registered address; stray reads return junk.
   assign cdata_rd = (crd && csel == 3'b101) ? featMem[caddr_rd[3:0]] : 20'hABCDE;
   assign wdata    = wrd ? wMem[int'(waddr)] : 20'h5A5A5;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycleCnt);
      end
   endtask

   function automatic logic [19:0] modelNeuron(input int n);
      longint acc;
      longint r;
      acc = 0;
      for (int k = 0; k < N_IN; k++)
         acc += longint'(featMem[k]) * longint'($signed(wMem[n*N_IN+k]));
      acc += longint'($signed(wMem[N_OUT*N_IN+n])) * 65536;
      r = (acc + 32768) >>> 16;
`ifdef DENSE_RELU_EN
      if (r < 0) return 20'h00000;
`else
      if (r < -524288) return 20'h80000;
`endif
      if (r > 524287) return 20'h7FFFF;
      return r[19:0];
   endfunction

   task automatic computeModel();
      for (int n = 0; n < N_OUT; n++) expData[n] = modelNeuron(n);
   endtask

   task automatic loadUniform(input logic [19:0] f, input logic [19:0] w, input logic [19:0] b);
      for (int k = 0; k < N_IN; k++) featMem[k] = f;
      for (int i = 0; i < N_OUT*N_IN; i++) wMem[i] = w;
      for (int n = 0; n < N_OUT; n++) wMem[N_OUT*N_IN+n] = b;
      computeModel();
   endtask

   task automatic loadMixed();
      int wv;
      for (int k = 0; k < N_IN; k++) featMem[k] = 20'(k*32'h3A51 + 32'h0400);
      for (int n = 0; n < N_OUT; n++)
         for (int k = 0; k < N_IN; k++) begin
            wv = ((k % 3) == 0) ? -(k*529 + 4096) : (k*311 + n*2048);
            wMem[n*N_IN+k] = 20'(wv);
         end
      wMem[N_OUT*N_IN]   = 20'hFC000;
      wMem[N_OUT*N_IN+1] = 20'h00480;
      computeModel();
   endtask

   // Pulses start and records the edge at which an idle design accepts it.
   task automatic applyStimulus();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      acceptCycle = cycleCnt;
      validCount = 0;
      doneCount = 0;
      doneRel = -1;
      for (int n = 0; n < N_OUT; n++) gotData[n] = '0;
      active = 1'b1;
   endtask

   task automatic waitRun();
      while (cycleCnt - acceptCycle < TOTAL + 4) @(posedge clk);
      #1;
   endtask

   task automatic pulseIgnored();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   // Expected output timeline relative to the accepting edge, derived from the
   // per-neuron cycle budget: N_IN reads, bias, two drain cycles, result.
   always @(negedge clk) begin
      if (reset) begin
         heldIdx = '0;
         heldData = '0;
         checkOutput("busy_rst", 32'(busy), 0);
         checkOutput("crd_rst", 32'(crd), 0);
         checkOutput("wrd_rst", 32'(wrd), 0);
         checkOutput("valid_rst", 32'(out_valid), 0);
         checkOutput("done_rst", 32'(done), 0);
         checkOutput("caddr_rst", 32'(caddr_rd), 0);
         checkOutput("waddr_rst", 32'(waddr), 0);
         checkOutput("csel_rst", 32'(csel), 0);
         checkOutput("idx_rst", 32'(out_idx), 0);
         checkOutput("data_rst", 32'(out_data), 0);
      end else begin
         c = active ? cycleCnt - acceptCycle : -1;
         eBusy = active && c >= 0 && c <= TOTAL + 1;
         eDone = active && c == TOTAL + 1;
         eCrd = 1'b0;
         eWrd = 1'b0;
         eValid = 1'b0;
         nn = 0;
         j = 0;
         if (active && c >= 1 && c <= TOTAL) begin
            nn = (c - 1) / PER;
            j = (c - 1) % PER;
            eCrd = j < N_IN;
            eWrd = j <= N_IN;
            eValid = j == PER - 1;
         end
         checkOutput("busy", 32'(busy), 32'(eBusy));
         checkOutput("done", 32'(done), 32'(eDone));
         checkOutput("crd", 32'(crd), 32'(eCrd));
         checkOutput("wrd", 32'(wrd), 32'(eWrd));
         checkOutput("out_valid", 32'(out_valid), 32'(eValid));
         checkOutput("csel", 32'(csel), eCrd ? 32'h5 : 32'h0);
         if (eCrd) begin
            checkOutput("caddr_rd", 32'(caddr_rd), 32'(j));
            checkOutput("waddr_w", 32'(waddr), 32'(nn*N_IN + j));
         end else if (eWrd) begin
            checkOutput("waddr_b", 32'(waddr), 32'(N_OUT*N_IN + nn));
         end
         if (out_valid) validCount++;
         if (done) begin
            doneCount++;
            doneRel = c;
         end
         if (eValid) begin
            heldIdx = IW'(nn);
            heldData = expData[nn];
            gotData[nn] = out_data;
         end
         checkOutput("out_idx", 32'(out_idx), 32'(heldIdx));
         checkOutput("out_data", 32'(out_data), 32'(heldData));
      end
   end

   initial begin
      reset = 1'b1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      $display("[TB] scenario 1: unity features, 1/16 weights");
      loadUniform(20'h10000, 20'h01000, 20'h00000);
      applyStimulus();
      waitRun();
      checkOutput("s1_n0", 32'(gotData[0]), 32'h10000);
      checkOutput("s1_n1", 32'(gotData[1]), 32'h10000);
      checkOutput("s1_done_cycle", 32'(doneRel), 32'(2*20+1));

      $display("[TB] scenario 2: negative weights");
      loadUniform(20'h10000, 20'hFF000, 20'h00000);
      applyStimulus();
      waitRun();
      checkOutput("s2_n0", 32'(gotData[0]), 32'(S2_EXP));
      checkOutput("s2_n1", 32'(gotData[1]), 32'(S2_EXP));

      $display("[TB] scenario 3: positive saturation");
      loadUniform(20'h10000, 20'h10000, 20'h10000);
      applyStimulus();
      waitRun();
      checkOutput("s3_n0", 32'(gotData[0]), 32'h7FFFF);
      checkOutput("s3_n1", 32'(gotData[1]), 32'h7FFFF);

      $display("[TB] scenario 4: round half up");
      loadUniform(20'h00000, 20'h00000, 20'h00000);
      featMem[3] = 20'h00001;
      wMem[3] = 20'h08000;
      wMem[N_IN+3] = 20'h08000;
      computeModel();
      applyStimulus();
      waitRun();
      checkOutput("s4_n0", 32'(gotData[0]), 32'h00001);
      checkOutput("s4_n1", 32'(gotData[1]), 32'h00001);

      $display("[TB] scenario 5: reset mid-fetch, then full run");
      loadMixed();
      applyStimulus();
      repeat (8) @(posedge clk);
      #1 reset = 1'b1;
      active = 1'b0;
      checkOutput("s5_valid_before_reset", 32'(validCount), 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      applyStimulus();
      waitRun();
      checkOutput("s5_n0", 32'(gotData[0]), 32'(expData[0]));
      checkOutput("s5_n1", 32'(gotData[1]), 32'(expData[1]));
      checkOutput("s5_valid_count", 32'(validCount), 32'(N_OUT));

      $display("[TB] scenario 6: start while busy");
      applyStimulus();
      repeat (5) @(posedge clk);
      pulseIgnored();
      repeat (18) @(posedge clk);
      pulseIgnored();
      waitRun();
      checkOutput("s6_valid_count", 32'(validCount), 32'(N_OUT));
      checkOutput("s6_done_count", 32'(doneCount), 1);
      checkOutput("s6_n0", 32'(gotData[0]), 32'(expData[0]));
      checkOutput("s6_n1", 32'(gotData[1]), 32'(expData[1]));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
